safe_entry_ctrl: RTL and testbench
==================================

SAFE_ENTRY_CTRL -- requirements
Module: safe_entry_ctrl

Interface
REQ-001 Parameter: MAX_FAILS, 3, consecutive failed attempts before lockout (1..15).
REQ-002 Parameter: LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (1..2^16-1).
REQ-003 Parameter: TIMEOUT_CYCLES, 255, inter-character idle limit in cycles (1..2^16-1); used only under SAFE_CTRL_TIMEOUT_EN.
REQ-004 Clocking: one clock; reset is synchronous and active-low.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst_n  in  1  synchronous active-low reset.
REQ-007 Port: in_valid  in  1  character offered.
REQ-008 Port: in_data  in  7  7-bit character.
REQ-009 Port: in_ready  out  1  character accepted when in_valid and in_ready are both high.
REQ-010 Port: abort  in  1  discard the partial entry.
REQ-011 Port: relock  in  1  leave OPEN.
REQ-012 Port: chk_match  in  1  external comparator result for code_word; combinational and sampled in CHECK.
REQ-013 Port: code_word  out  56  slot k at bits [7k+6:7k].
REQ-014 Port: code_valid  out  1  high only in CHECK.
REQ-015 Port: unlocked  out  1  high in OPEN.
REQ-016 Port: locked_out  out  1  high in LOCKOUT.
REQ-017 Port: fail_cnt  out  4  consecutive failures.

Function
REQ-018 The FSM SHALL have the states COLLECT, CHECK, OPEN and LOCKOUT, and SHALL come out of reset in COLLECT.
REQ-019 The block SHALL hold an 8x7 slot array, a 3-bit slot pointer and a 4-bit entry count.
- On each accept: slot[ptr] <= in_data; ptr <= (ptr+5) mod 8; count increments.
- Accept order k=0..7 therefore fills slots 0,5,2,7,4,1,6,3.
REQ-020 in_ready SHALL equal (state==COLLECT) and not abort.
REQ-021 In COLLECT, abort SHALL clear ptr and count and keep slot contents; abort has priority over a simultaneous in_valid, whose character is not accepted.
REQ-022 The 8th accept (count 7->8) SHALL move the FSM to CHECK on the next edge; a 9th character is never accepted in the same entry.
REQ-023 CHECK SHALL last exactly one cycle with code_valid=1 and chk_match sampled at its closing edge.
- chk_match=1: go to OPEN; fail_cnt <= 0.
- chk_match=0 and fail_cnt+1 < MAX_FAILS: fail_cnt increments; go to COLLECT with ptr=0 and count=0.
- chk_match=0 and fail_cnt+1 == MAX_FAILS: fail_cnt <= MAX_FAILS; go to LOCKOUT.
REQ-024 OPEN SHALL hold unlocked=1 until relock=1, then go to COLLECT with ptr=0, count=0, and slots cleared to 0.
REQ-025 LOCKOUT SHALL load a 16-bit down-counter with LOCKOUT_CYCLES-1 on entry, keep in_ready=0, and ignore abort and relock.
- When the counter reads 0: go to COLLECT; fail_cnt <= 0.
- locked_out stays high for exactly LOCKOUT_CYCLES cycles.
REQ-026 code_word SHALL be driven directly from the slot registers in every state; there is no added latency.
REQ-027 Between its input handshake and code_valid, the block SHALL have a minimum latency of 8 accept cycles plus 1 cycle.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL reset:
- State to COLLECT; ptr, count, fail_cnt, slots, and the lockout and timeout counters to 0.
- Outputs: in_ready=1 once rst_n=1; code_valid=0; unlocked=0; locked_out=0; code_word=0.
REQ-029 A reset asserted in any state, including mid-entry or mid-lockout, SHALL take effect at the next edge and SHALL override every other input.

Configuration
REQ-030 Macro SAFE_CTRL_TIMEOUT_EN, when defined, SHALL enable the inter-character timeout:
- In COLLECT with count>0, a 16-bit counter tracks idle cycles and is reset by each accept.
- After TIMEOUT_CYCLES cycles with no accept, ptr and count clear; this does not count as a failure.
REQ-031 When SAFE_CTRL_TIMEOUT_EN is undefined, no timeout logic SHALL exist and a partial entry SHALL persist indefinitely.

Verification
REQ-032 Scenario, stride fill: send 0x01..0x08 back-to-back with chk_match=0 -> slots 0..7 = 01,06,03,08,05,02,07,04; code_valid pulses for exactly 1 cycle, 1 cycle after the 8th accept; fail_cnt=1.
REQ-033 Scenario, successful unlock: send 8 characters, drive chk_match=1 in CHECK -> unlocked=1 and in_ready=0 until relock; relock gives COLLECT with code_word=0 on the next cycle.
REQ-034 Scenario, lockout: with MAX_FAILS=3 and LOCKOUT_CYCLES=10, make 3 failed entries -> locked_out high for exactly 10 cycles, in_ready=0 throughout, then fail_cnt=0 and in_ready=1.
REQ-035 Scenario, abort collision: after 3 accepts, assert abort and in_valid together with 0x7F -> 0x7F is not accepted; the next 8 characters fill slots starting from slot 0.
REQ-036 Scenario, reset mid-operation: pulse rst_n low for 1 cycle at the 5th cycle of lockout -> locked_out=0, fail_cnt=0, in_ready=1 after release.
REQ-037 Scenario, timeout (macro defined, TIMEOUT_CYCLES=4): accept 2 characters, then idle 4 cycles -> count=0 and fail_cnt unchanged; without the macro, count stays 2.

Source files
------------

// File: rtl/safe_entry_ctrl.sv
// safe_entry_ctrl: keypad entry FSM with stride-filled 8x7 slot array, match check, and fail lockout.
// Define SAFE_CTRL_TIMEOUT_EN to clear a partial entry after TIMEOUT_CYCLES idle cycles.
module safe_entry_ctrl #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  in_data,
  output logic        in_ready,
  input  logic        abort,
  input  logic        relock,
  input  logic        chk_match,
  output logic [55:0] code_word,
  output logic        code_valid,
  output logic        unlocked,
  output logic        locked_out,
  output logic [3:0]  fail_cnt
);
  localparam logic [1:0] COLLECT = 2'd0, CHECK = 2'd1, OPEN = 2'd2, LOCKOUT = 2'd3;
  localparam logic [3:0]  MF = 4'(MAX_FAILS);
  localparam logic [15:0] LC = 16'(LOCKOUT_CYCLES - 1);
  logic [1:0]  r_state;
  logic [6:0]  r_slot [8];
  logic [2:0]  r_ptr;
  logic [3:0]  r_cnt, r_fail;
  logic [15:0] r_lock;
  logic        w_accept, w_tmo_hit;
  assign in_ready   = r_state == COLLECT && !abort;
  assign w_accept   = in_valid && in_ready;
  assign code_valid = r_state == CHECK;
  assign unlocked   = r_state == OPEN;
  assign locked_out = r_state == LOCKOUT;
  assign fail_cnt   = r_fail;
  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_cw
      assign code_word[7*k +: 7] = r_slot[k];
    end
  endgenerate
`ifdef SAFE_CTRL_TIMEOUT_EN
  localparam logic [15:0] TC = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo;
  assign w_tmo_hit = r_state == COLLECT && r_cnt != 4'd0 && r_tmo == TC;
  always_ff @(posedge clk)
    r_tmo <= (!rst_n || r_state != COLLECT || r_cnt == 4'd0 || w_accept || abort || w_tmo_hit) ? '0 : r_tmo + 16'd1;
`else
  logic w_unused;
  assign w_unused  = |16'(TIMEOUT_CYCLES);
  assign w_tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_fail  <= '0;
      r_lock  <= '0;
      for (int i = 0; i < 8; i++) r_slot[i] <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_slot[r_ptr] <= in_data;
            r_ptr         <= r_ptr + 3'd5;
            r_cnt         <= r_cnt + 4'd1;
            if (r_cnt == 4'd7) r_state <= CHECK;
          end else if (abort || w_tmo_hit) begin
            r_ptr <= '0;
            r_cnt <= '0;
          end
        end
        CHECK: begin
          r_ptr <= '0;
          r_cnt <= '0;
          if (chk_match) begin
            r_state <= OPEN;
            r_fail  <= '0;
          end else if (r_fail + 4'd1 == MF) begin
            r_state <= LOCKOUT;
            r_fail  <= MF;
            r_lock  <= LC;
          end else begin
            r_state <= COLLECT;
            r_fail  <= r_fail + 4'd1;
          end
        end
        OPEN: begin
          if (relock) begin
            r_state <= COLLECT;
            r_ptr   <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < 8; i++) r_slot[i] <= '0;
          end
        end
        LOCKOUT: begin
          if (r_lock == 16'd0) begin
            r_state <= COLLECT;
            r_fail  <= '0;
          end else r_lock <= r_lock - 16'd1;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_safe_entry_ctrl.sv
// tb_safe_entry_ctrl: directed vector table plus hand sequences for lockout, reset and timeout.
module tb_safe_entry_ctrl;
  logic        clk = 0, rst_n = 0, in_valid = 0, abort = 0, relock = 0, chk_match = 0;
  logic [6:0]  in_data = '0;
  logic        in_ready, code_valid, unlocked, locked_out;
  logic [55:0] code_word;
  logic [3:0]  fail_cnt;
  int checks = 0, errors = 0;
`ifdef SAFE_CTRL_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam logic [55:0] CW_S = {7'h04, 7'h07, 7'h02, 7'h05, 7'h08, 7'h03, 7'h06, 7'h01};
  localparam logic [55:0] CW_A = {7'h04, 7'h07, 7'h12, 7'h05, 7'h08, 7'h13, 7'h06, 7'h11};
  localparam logic [55:0] CW_B = {7'h24, 7'h27, 7'h22, 7'h25, 7'h28, 7'h23, 7'h26, 7'h21};
  safe_entry_ctrl #(.MAX_FAILS(3), .LOCKOUT_CYCLES(10), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .relock(relock), .chk_match(chk_match), .code_word(code_word),
    .code_valid(code_valid), .unlocked(unlocked), .locked_out(locked_out), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        iv;
    logic [6:0]  d;
    logic        ab, rl, m;
    logic [7:0]  exp;
    logic        ccw;
    logic [55:0] cw;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic iv, input logic [6:0] d, input logic ab, input logic rl, input logic m);
    @(negedge clk);
    in_valid = iv; in_data = d; abort = ab; relock = rl; chk_match = m;
    #1;
  endtask
  task automatic entry(input logic [6:0] base, input logic m);
    for (int i = 0; i < 8; i++) cyc(1'b1, base + 7'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 7'h0, 1'b0, 1'b0, m);
    chk("entry_code_valid", 64'(code_valid), 64'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 7'(i + 1), 1'b0, 1'b0, 1'b0, 8'b1000_0000, i == 0, 56'd0});
    tbl.push_back('{1'b1, 7'h55, 1'b0, 1'b0, 1'b0, 8'b0100_0000, 1'b1, CW_S});
    tbl.push_back('{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 8'b1000_0001, 1'b1, CW_S});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b1, 7'(8'h11 + i), 1'b0, 1'b0, 1'b0, 8'b1000_0001, i == 0, CW_S});
    tbl.push_back('{1'b1, 7'h7F, 1'b1, 1'b0, 1'b0, 8'b0000_0001, 1'b1, CW_A});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 7'(8'h21 + i), 1'b0, 1'b0, 1'b0, 8'b1000_0001, i == 0, CW_A});
    tbl.push_back('{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 8'b0100_0001, 1'b1, CW_B});
    tbl.push_back('{1'b1, 7'h33, 1'b0, 1'b0, 1'b0, 8'b0010_0000, 1'b1, CW_B});
    tbl.push_back('{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 8'b0010_0000, 1'b1, CW_B});
    tbl.push_back('{1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 8'b0010_0000, 1'b1, CW_B});
    tbl.push_back('{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 8'b1000_0000, 1'b1, 56'd0});
    repeat (2) @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) begin
      cyc(tbl[i].iv, tbl[i].d, tbl[i].ab, tbl[i].rl, tbl[i].m);
      chk($sformatf("vec%0d_flags", i), 64'({in_ready, code_valid, unlocked, locked_out, fail_cnt}), 64'(tbl[i].exp));
      if (tbl[i].ccw) chk($sformatf("vec%0d_code_word", i), 64'(code_word), 64'(tbl[i].cw));
    end
    begin : lockout
      int n, bad;
      entry(7'h40, 1'b0);
      entry(7'h48, 1'b0);
      entry(7'h50, 1'b0);
      n = 0; bad = 0;
      cyc(1'b1, 7'h01, 1'b1, 1'b1, 1'b0);
      chk("lock_fail_cnt", 64'(fail_cnt), 64'd3);
      while (locked_out && n < 50) begin
        if (in_ready || unlocked) bad++;
        n++;
        cyc(1'b1, 7'h01, 1'b1, 1'b1, 1'b0);
      end
      chk("lock_duration", 64'(n), 64'd10);
      chk("lock_ready_low", 64'(bad), 64'd0);
      cyc(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      chk("lock_exit", 64'({in_ready, locked_out, fail_cnt}), {58'd0, 2'b10, 4'd0});
    end
    entry(7'h10, 1'b0);
    entry(7'h18, 1'b0);
    entry(7'h20, 1'b0);
    repeat (4) cyc(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_locked", 64'({locked_out, fail_cnt}), {59'd0, 1'b1, 4'd3});
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_flags", 64'({in_ready, code_valid, unlocked, locked_out, fail_cnt}), 64'b1000_0000);
    chk("reset_code_word", 64'(code_word), 64'd0);
    entry(7'h60, 1'b0);
    cyc(1'b1, 7'h41, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h42, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
    chk("tmo_fail_cnt", 64'(fail_cnt), 64'd1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 7'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
    chk("tmo_count", 64'(code_valid), 64'(!TMO));
    chk("tmo_fail_after", 64'(fail_cnt), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
